imem_access_controller: RTL and testbench
=========================================

IMEM_ACCESS_CONTROLLER -- requirements
Module: imem_access_controller

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set address width of all address ports.
REQ-002 Parameter DATA_W, default 32, SHALL set data width of all data ports.
REQ-003 Parameter DEPTH, default 2048, SHALL set the number of valid memory words; addresses >= DEPTH are out of range.
REQ-004 Parameter STARVE_LIMIT, default 4, SHALL set the number of consecutive loader grants allowed while fetch waits.
REQ-005 clk  in  1  single clock; all state changes on posedge clk.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 fetch_req  in  1  fetch read request, held until accepted.
REQ-008 fetch_addr  in  ADDR_W  fetch word address, stable while fetch_req high.
REQ-009 fetch_ready  out  1  fetch request accepted on this posedge.
REQ-010 fetch_valid  out  1  one-cycle pulse, fetch_rdata/fetch_err valid.
REQ-011 fetch_rdata  out  DATA_W  fetched word.
REQ-012 fetch_err  out  1  out-of-range fetch, coincident with fetch_valid.
REQ-013 load_req  in  1  loader write request, held until accepted.
REQ-014 load_addr  in  ADDR_W  write word address.
REQ-015 load_wdata  in  DATA_W  write data.
REQ-016 load_ready  out  1  load request accepted on this posedge.
REQ-017 load_err  out  1  one-cycle pulse, out-of-range load dropped.
REQ-018 mem_rd  out  1  memory read enable.
REQ-019 mem_wn  out  1  memory write enable.
REQ-020 mem_address  out  ADDR_W  memory address.
REQ-021 mem_write_data  out  DATA_W  memory write data.
REQ-022 mem_read_data  in  DATA_W  memory read data, registered by memory on posedge when mem_rd=1, mem_wn=0.

Function
REQ-023 FSM states SHALL be IDLE, RD_ISSUE, RD_RESP, WR_ISSUE; requests accepted only in IDLE.
REQ-024 fetch_ready and load_ready SHALL be combinational, high only in IDLE for the granted requester; at most one high per cycle.
REQ-025 Arbitration: loader priority when both request, except fetch granted when starve counter == STARVE_LIMIT.
REQ-026 Starve counter SHALL increment on each loader grant with fetch_req high, clear on fetch grant or loader grant with fetch_req low, saturate at STARVE_LIMIT.
REQ-027 Fetch accept: IDLE -> RD_ISSUE; address captured; mem_rd=1, mem_wn=0, mem_address=captured address during RD_ISSUE (mem_rd=0 if out of range).
REQ-028 RD_ISSUE -> RD_RESP unconditionally; in RD_RESP fetch_valid=1, fetch_rdata=mem_read_data (0 if out of range), fetch_err=out-of-range flag; RD_RESP -> IDLE.
REQ-029 Fetch latency SHALL be 2 cycles from accepting edge to fetch_valid; fetch throughput 1 per 3 cycles.
REQ-030 Load accept: IDLE -> WR_ISSUE; in WR_ISSUE mem_wn=1, mem_rd=0, mem_address/mem_write_data=captured values; WR_ISSUE -> IDLE; throughput 1 per 2 cycles.
REQ-031 Out-of-range load SHALL keep mem_wn=0 in WR_ISSUE and pulse load_err during WR_ISSUE.
REQ-032 mem_rd and mem_wn SHALL never be high simultaneously; both 0 in IDLE and RD_RESP.
REQ-033 fetch_valid, fetch_err, load_err SHALL be 0 in all states not listed above.
REQ-034 Requests deasserted before acceptance SHALL be ignored with no memory access.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, starve counter 0, mem_rd=0, mem_wn=0, mem_address=0, mem_write_data=0, fetch_valid=0, fetch_rdata=0, fetch_err=0, load_err=0.
REQ-036 Reset mid-transaction SHALL drop it: no fetch_valid and no memory write thereafter.
REQ-037 First acceptance SHALL be possible on the first posedge after rst_n rises.

Verification
REQ-038 Fetch addr 0x0010, memory word 0xDEADBEEF -> mem_rd high 1 cycle later, fetch_valid with fetch_rdata=0xDEADBEEF 2 cycles after accept, fetch_err=0.
REQ-039 Load addr 0x0005 data 0x12345678 then fetch 0x0005 -> mem_wn one cycle, subsequent fetch returns 0x12345678.
REQ-040 Fetch 0x0800 and load 0x0900 (DEPTH=2048) -> fetch_err with rdata 0, load_err pulse, mem_rd/mem_wn never asserted.
REQ-041 load_req and fetch_req held high continuously -> 4 load grants, then 1 fetch grant, pattern repeats; never both ready.
REQ-042 rst_n low during RD_ISSUE -> outputs zero asynchronously, no fetch_valid; accept on first edge after release.
REQ-043 Every cycle of all tests -> assert !(mem_rd && mem_wn) and at most one of fetch_ready/load_ready.

Source files
------------

// File: rtl/imem_access_controller.sv
// Arbitrates fetch reads and loader writes onto a single-port instruction memory.
// Fetch takes 3 cycles and load takes 2 cycles. Loader has priority, but fetch is granted once it has starved STARVE_LIMIT times.
module imem_access_controller #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 2048,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_rdata,
    output logic              fetch_err,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_wdata,
    output logic              load_ready,
    output logic              load_err,
    output logic              mem_rd,
    output logic              mem_wn,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [ADDR_W:0] DEPTH_W    = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_RESP, WR_ISSUE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SW-1:0]     starve_cnt;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic              cap_oor;
    logic              grant_fetch;
    logic              grant_load;
    logic              fetch_oor;
    logic              load_oor;

    assign fetch_oor = {1'b0, fetch_addr} >= DEPTH_W;
    assign load_oor  = {1'b0, load_addr} >= DEPTH_W;

    // The loader wins unless a waiting fetch has already been passed over STARVE_LIMIT times.
    always_comb begin
        grant_load  = 1'b0;
        grant_fetch = 1'b0;
        if (state == IDLE) begin
            if (load_req && !(fetch_req && starve_cnt == STARVE_MAX)) begin
                grant_load = 1'b1;
            end else if (fetch_req) begin
                grant_fetch = 1'b1;
            end
        end
    end

    assign fetch_ready = grant_fetch;
    assign load_ready  = grant_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_load) begin
                    state_nxt = WR_ISSUE;
                end else if (grant_fetch) begin
                    state_nxt = RD_ISSUE;
                end
            end
            RD_ISSUE: state_nxt = RD_RESP;
            RD_RESP:  state_nxt = IDLE;
            WR_ISSUE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            cap_addr   <= '0;
            cap_data   <= '0;
            cap_oor    <= 1'b0;
        end else if (grant_fetch) begin
            starve_cnt <= '0;
            cap_addr   <= fetch_addr;
            cap_oor    <= fetch_oor;
        end else if (grant_load) begin
            cap_addr <= load_addr;
            cap_data <= load_wdata;
            cap_oor  <= load_oor;
            if (!fetch_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

    // Outputs decode purely from state, so an asserted reset zeroes them without waiting for a clock.
    always_comb begin
        mem_rd         = 1'b0;
        mem_wn         = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        fetch_valid    = 1'b0;
        fetch_rdata    = '0;
        fetch_err      = 1'b0;
        load_err       = 1'b0;
        case (state)
            RD_ISSUE: begin
                mem_rd      = !cap_oor;
                mem_address = cap_addr;
            end
            RD_RESP: begin
                fetch_valid = 1'b1;
                fetch_err   = cap_oor;
                fetch_rdata = cap_oor ? '0 : mem_read_data;
            end
            WR_ISSUE: begin
                mem_wn         = !cap_oor;
                load_err       = cap_oor;
                mem_address    = cap_addr;
                mem_write_data = cap_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imem_access_controller.sv
// Directed and random checks of imem_access_controller against a word-array memory model.
module tb_imem_access_controller;

    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 32;
    localparam int DEPTH        = 2048;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_rdata;
    logic              fetch_err;
    logic              load_req = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [DATA_W-1:0] load_wdata = '0;
    logic              load_ready;
    logic              load_err;
    logic              mem_rd;
    logic              mem_wn;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data = '0;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int exp_wr = 0;

    logic [DATA_W-1:0] env_mem [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];

    imem_access_controller #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
        .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata),
        .load_ready(load_ready), .load_err(load_err),
        .mem_rd(mem_rd), .mem_wn(mem_wn), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Synchronous memory: registered read data, counts every write strobe it sees.
    always @(posedge clk) begin
        if (mem_wn) begin
            wr_cnt <= wr_cnt + 1;
            if (int'(mem_address) < DEPTH) env_mem[mem_address] <= mem_write_data;
        end
        if (mem_rd && !mem_wn && int'(mem_address) < DEPTH)
            mem_read_data <= env_mem[mem_address];
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        chk("rd_wn_exclusive", mem_rd && mem_wn, 0);
        chk("one_ready", fetch_ready && load_ready, 0);
    endtask

    task automatic do_fetch(input logic [ADDR_W-1:0] a, input bit inject);
        logic              oor;
        logic [DATA_W-1:0] exp;
        int                n;
        oor = int'(a) >= DEPTH;
        exp = '0;
        if (!oor) exp = ref_mem[a];
        fetch_req = 1'b1;
        fetch_addr = a;
        #1;
        n = 0;
        while (!fetch_ready && n < 8) begin
            tick();
            n++;
        end
        chk("fetch_ready", fetch_ready, 1);
        tick();
        fetch_req = 1'b0;
        fetch_addr = ADDR_W'($urandom);
        #1;
        chk("rd_issue_mem_rd", mem_rd, !oor);
        chk("rd_issue_mem_wn", mem_wn, 0);
        chk("rd_issue_addr", mem_address, a);
        chk("rd_issue_valid", fetch_valid, 0);
        if (inject) begin
            load_req = 1'b1;
            load_addr = ADDR_W'($urandom_range(0, 31));
            load_wdata = $urandom;
            #1;
            chk("busy_load_ready", load_ready, 0);
        end
        tick();
        chk("resp_valid", fetch_valid, 1);
        chk("resp_rdata", fetch_rdata, exp);
        chk("resp_err", fetch_err, oor);
        chk("resp_mem_rd", mem_rd, 0);
        chk("resp_load_ready", load_ready, 0);
        load_req = 1'b0;
        tick();
        chk("idle_valid", fetch_valid, 0);
        chk("fetch_write_count", wr_cnt, exp_wr);
    endtask

    task automatic do_load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic oor;
        int   n;
        oor = int'(a) >= DEPTH;
        load_req = 1'b1;
        load_addr = a;
        load_wdata = d;
        #1;
        n = 0;
        while (!load_ready && n < 8) begin
            tick();
            n++;
        end
        chk("load_ready", load_ready, 1);
        tick();
        load_req = 1'b0;
        load_addr = ADDR_W'($urandom);
        load_wdata = $urandom;
        #1;
        chk("wr_issue_mem_wn", mem_wn, !oor);
        chk("wr_issue_mem_rd", mem_rd, 0);
        chk("wr_issue_load_err", load_err, oor);
        chk("wr_issue_addr", mem_address, a);
        chk("wr_issue_wdata", mem_write_data, d);
        if (!oor) begin
            ref_mem[a] = d;
            exp_wr++;
        end
        tick();
        chk("post_load_err", load_err, 0);
        chk("post_load_wn", mem_wn, 0);
        chk("load_write_count", wr_cnt, exp_wr);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int               cnt;
        int               grants;
        bit               exp_f;
        logic [ADDR_W-1:0] a;

        for (int i = 0; i < DEPTH; i++) begin
            env_mem[i] = DATA_W'(i) * 32'h9E37_79B1;
            ref_mem[i] = DATA_W'(i) * 32'h9E37_79B1;
        end

        // Reset state
        tick();
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wn", mem_wn, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_write_data", mem_write_data, 0);
        chk("rst_fetch_valid", fetch_valid, 0);
        chk("rst_fetch_rdata", fetch_rdata, 0);
        chk("rst_fetch_err", fetch_err, 0);
        chk("rst_load_err", load_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Known word fetch, then load-then-fetch
        env_mem[16] = 32'hDEAD_BEEF;
        ref_mem[16] = 32'hDEAD_BEEF;
        do_fetch(16'h0010, 1'b0);
        do_load(16'h0005, 32'h1234_5678);
        do_fetch(16'h0005, 1'b0);

        // Out-of-range accesses, including the first word past the end
        do_fetch(16'h0800, 1'b0);
        do_load(16'h0900, 32'hCAFE_F00D);
        do_fetch(16'h07FF, 1'b1);
        do_load(16'hFFFF, 32'h0BAD_0BAD);

        // Both requesters held high: starvation window
        do_reset();
        fetch_req = 1'b1;
        fetch_addr = 16'h0003;
        load_req = 1'b1;
        load_addr = 16'h0007;
        load_wdata = 32'hA5A5_0000;
        #1;
        cnt = 0;
        grants = 0;
        for (int c = 0; c < 60; c++) begin
            if (fetch_ready || load_ready) begin
                exp_f = (cnt == STARVE_LIMIT);
                chk("arb_fetch", fetch_ready, exp_f);
                chk("arb_load", load_ready, !exp_f);
                if (exp_f) begin
                    cnt = 0;
                end else begin
                    cnt = (cnt < STARVE_LIMIT) ? cnt + 1 : STARVE_LIMIT;
                    ref_mem[7] = 32'hA5A5_0000;
                    exp_wr++;
                end
                grants++;
            end
            if (fetch_valid) chk("starve_rdata", fetch_rdata, ref_mem[3]);
            tick();
        end
        fetch_req = 1'b0;
        load_req = 1'b0;
        chk("arb_progress", grants >= 20, 1);
        tick();
        tick();
        tick();
        chk("starve_write_count", wr_cnt, exp_wr);

        // Reset during a read issue drops the read
        fetch_req = 1'b1;
        fetch_addr = 16'h0010;
        #1;
        chk("pre_reset_ready", fetch_ready, 1);
        tick();
        fetch_req = 1'b0;
        chk("pre_reset_mem_rd", mem_rd, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_rd", mem_rd, 0);
        chk("async_rst_addr", mem_address, 0);
        chk("async_rst_valid", fetch_valid, 0);
        tick();
        chk("held_rst_valid", fetch_valid, 0);
        tick();
        chk("held_rst_valid2", fetch_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_fetch(16'h0010, 1'b0);
        chk("reset_write_count", wr_cnt, exp_wr);

        // Random mix of fetches and loads
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 9) == 0)
                a = ADDR_W'(DEPTH + $urandom_range(0, 300));
            else
                a = ADDR_W'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1)
                do_load(a, $urandom);
            else
                do_fetch(a, bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
